// File: rtl/test_status_monitor_pkg.sv
// Shared state encoding, default register indices and sizing helper for the
// test status monitor.
package test_status_monitor_pkg;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_DRAIN = 2'd2,
    MON_DONE  = 2'd3
  } mon_state_e;

  localparam int MON_END_REG  = 26;
  localparam int MON_PASS_REG = 27;
  localparam int MON_TNUM_REG = 3;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/test_status_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of
// wrapping.
module mon_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/test_status_monitor.sv
// Observer beside the core: snoops register write-back, tracks end/pass/test
// number and a timeout budget, and reports sticky done/pass/fail/timeout.
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RADDR_W        = 5,
  parameter int END_REG        = MON_END_REG,
  parameter int PASS_REG       = MON_PASS_REG,
  parameter int TNUM_REG       = MON_TNUM_REG,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DRAIN_CYCLES   = 15,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [XLEN-1:0]    test_num,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   wb_cnt,
  output logic [1:0]         state
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES - 1);
  localparam int DW = cnt_width(DRAIN_CYCLES);
  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  mon_state_e      state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [XLEN-1:0] end_sh_q, end_sh_d;
  logic [XLEN-1:0] pass_sh_q, pass_sh_d;
  logic [XLEN-1:0] tnum_sh_q, tnum_sh_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic            fail_q, fail_d, timeout_q, timeout_d;
  logic            qual, end_trig, active, finish, finish_tmo;

  assign qual   = wb_en && (wb_addr != '0);
  assign active = (state_q == MON_RUN) || (state_q == MON_DRAIN);

  // Shadows see this cycle's write, so pass evaluation honours a same-cycle PASS_REG write.
  always_comb begin
    end_sh_d  = end_sh_q;
    pass_sh_d = pass_sh_q;
    tnum_sh_d = tnum_sh_q;
    if (qual && (state_q != MON_DONE)) begin
      if (wb_addr == RADDR_W'(END_REG))  end_sh_d  = wb_data;
      if (wb_addr == RADDR_W'(PASS_REG)) pass_sh_d = wb_data;
      if (wb_addr == RADDR_W'(TNUM_REG)) tnum_sh_d = wb_data;
    end
  end

  assign end_trig = qual && (wb_addr == RADDR_W'(END_REG)) && (end_sh_d == ONE);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    drain_d    = drain_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    finish     = 1'b0;
    finish_tmo = 1'b0;
    case (state_q)
      MON_IDLE: begin
        tmo_d = '0;
        if (arm) state_d = MON_RUN;
      end
      MON_RUN: begin
        tmo_d = tmo_q + TW'(1);
        // An end trigger beats a simultaneous timeout.
        if (end_trig) begin
          if (DRAIN_CYCLES == 0) begin
            finish = 1'b1;
          end else begin
            state_d = MON_DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end
      end
      MON_DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) finish = 1'b1;
      end
      default: ;
    endcase
    if (finish) begin
      state_d   = MON_DONE;
      done_d    = 1'b1;
      timeout_d = finish_tmo;
      pass_d    = !finish_tmo && (pass_sh_d == ONE);
      fail_d    = !(!finish_tmo && (pass_sh_d == ONE));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MON_IDLE;
      tmo_q     <= '0;
      drain_q   <= '0;
      end_sh_q  <= '0;
      pass_sh_q <= '0;
      tnum_sh_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      drain_q   <= drain_d;
      end_sh_q  <= end_sh_d;
      pass_sh_q <= pass_sh_d;
      tnum_sh_q <= tnum_sh_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == MON_IDLE),
    .en  (active),
    .q   (cycle_cnt)
  );

  mon_sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == MON_IDLE),
    .en  (active && qual),
    .q   (wb_cnt)
  );

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign test_num = tnum_sh_q;
  assign state    = state_q;

endmodule
